prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//   Byte-stream boot loader for the 16-bit CPU. Receives framed bytes (host/UART side), assembles
//   16-bit words and writes them into instruction or data memory through a dedicated write port.
//   Holds the CPU in reset until a valid RUN frame arrives; afterwards the CPU runs from the loaded image.
// PARAMETERS
//   ADDR_W     8      word-address width of imem/dmem write port
//   SYNC_BYTE  8'hA5  frame start marker
// PORTS
//   clk         in   1       system clock, all logic on posedge
//   rst         in   1       asynchronous, active-high reset
//   in_valid    in   1       input byte valid
//   in_data     in   8       input byte
//   in_ready    out  1       loader accepts byte; transfer = in_valid & in_ready
//   imem_we     out  1       one-cycle write strobe to instruction memory
//   dmem_we     out  1       one-cycle write strobe to data memory
//   mem_addr    out  ADDR_W  word address for either strobe
//   mem_wdata   out  16      word to write
//   cpu_rst     out  1       reset to CPU core; 1 until RUN accepted
//   busy        out  1       1 while inside a frame (state not IDLE/RUN)
//   err         out  1       sticky: bad command or checksum; cleared only by rst
// BEHAVIOUR
//   Reset: state=IDLE, in_ready=1, imem_we=dmem_we=0, mem_addr=0, mem_wdata=0, cpu_rst=1, busy=0, err=0.
//   Frame: SYNC, CMD, [ADDR_H, ADDR_L, LEN_H, LEN_L, LEN x (DATA_H, DATA_L)], CSUM.
//     CMD 8'h00 = load imem, 8'h01 = load dmem, 8'hFF = RUN (no address/len/data fields).
//   CSUM: 8-bit sum of every byte from CMD through CSUM inclusive must be 8'h00 (mod 256).
//   States: IDLE, CMD, ADDR_H, ADDR_L, LEN_H, LEN_L, DATA_H, DATA_L, CSUM, RUN.
//     IDLE: SYNC -> CMD; any other byte dropped silently, no err.
//     CMD: 00/01 -> ADDR_H (latch target); FF -> CSUM; other -> err=1, IDLE.
//     ADDR_H/L: 16-bit word address; only low ADDR_W bits used, upper bits ignored.
//     LEN_H/L: 16-bit word count; LEN=0 -> CSUM directly after LEN_L.
//     DATA_H: latch high byte. DATA_L: issue write, decrement count; count 0 -> CSUM else DATA_H.
//     CSUM: sum==0 and cmd==FF -> RUN; sum!=0 -> err=1; else IDLE.
//     RUN: in_ready=0, cpu_rst=0, stays until rst.
//   Handshake: in_ready=1 in every state except RUN; one byte consumed per accepted cycle, no bubbles.
//   Write timing: cycle after DATA_L handshake, exactly one of imem_we/dmem_we=1 for one cycle with
//     mem_addr=current address, mem_wdata={DATA_H,DATA_L}; strobe low otherwise. Address then +1,
//     wrapping mod 2^ADDR_W (0xFF -> 0x00 at ADDR_W=8). Back-to-back words give strobes every 2nd cycle.
//   Writes are streamed, not buffered: a bad CSUM does not undo writes already issued (err flags it).
//   cpu_rst drops in the cycle after the accepting CSUM handshake of a good RUN frame; never reasserts
//     except through rst.
//   SYNC byte inside a frame is ordinary data (no resync). rst mid-frame: all state to reset values,
//     in-flight write strobe suppressed, cpu_rst=1.
//   Checksum accumulator: 8-bit, cleared on SYNC, adds every accepted byte from CMD onward, overflow wraps.
// STRUCTURE
//   Shared package cpu_pkg: loader command codes (CMD_LOAD_IMEM/CMD_LOAD_DMEM/CMD_RUN), SYNC default,
//     loader state enum.
//   Single module; no sub-module needed. Top-level muxes mem write port into imem/dmem write ports
//     alongside the CPU data path (dmem) while cpu_rst=1.
// TESTING
//   1 Load imem: A5 00 00 00 00 01 00 54 AB -> one imem_we, addr 0x00, wdata 0x0054; err=0, cpu_rst=1.
//   2 Wrap: A5 01 00 FF 00 02 12 34 AB CD 40 -> dmem_we addr 0xFF data 0x1234, then addr 0x00
//     data 0xABCD (strobes 2 cycles apart); err=0.
//   3 Run: A5 FF 01 -> cpu_rst falls one cycle after last byte, in_ready=0, later bytes ignored;
//     A5 FF 02 instead -> err=1, cpu_rst stays 1.
//   4 Junk/bad cmd: 00 13 A5 07 ... -> leading bytes dropped no err; CMD 07 sets err, returns IDLE;
//     next valid frame still loads.
//   5 Zero length + backpressure: A5 00 00 10 00 00 F0 with in_valid toggling -> no write strobe,
//     err=0, busy high only inside frame.
//   6 Reset mid-frame: rst pulse after DATA_H byte -> no strobe, all outputs reset values, new frame OK.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: boot loader command codes, frame marker and loader state encoding.
package cpu_pkg;

    localparam logic [7:0] CMD_LOAD_IMEM = 8'h00;
    localparam logic [7:0] CMD_LOAD_DMEM = 8'h01;
    localparam logic [7:0] CMD_RUN       = 8'hFF;
    localparam logic [7:0] SYNC_DEFAULT  = 8'hA5;

    typedef enum logic [3:0] {
        LD_IDLE,
        LD_CMD,
        LD_ADDR_H,
        LD_ADDR_L,
        LD_LEN_H,
        LD_LEN_L,
        LD_DATA_H,
        LD_DATA_L,
        LD_CSUM,
        LD_RUN
    } loader_state_e;

endpackage

// File: rtl/prog_loader.sv
// Byte-stream boot loader: parses SYNC/CMD/ADDR/LEN/DATA/CSUM frames, streams 16-bit words into
// imem/dmem and releases the CPU reset once a RUN frame with a good checksum is accepted.
module prog_loader
    import cpu_pkg::*;
#(
    parameter int         ADDR_W    = 8,
    parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              err,
    output loader_state_e     dbg_state
);

    // Handshake: a byte is consumed on every rising clk edge where in_valid && in_ready;
    // in_ready is high in every state except RUN, so no bubbles are inserted by the loader.

    loader_state_e     state_q, state_d;
    logic [7:0]        sum_q;
    logic [7:0]        sum_next;
    logic              tgt_dmem_q;
    logic              run_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       cnt_q;
    logic [7:0]        data_h_q;
    logic              xfer;
    logic              wr_fire;
    logic              err_set;

    assign in_ready  = (state_q != LD_RUN);
    assign cpu_rst   = (state_q != LD_RUN);
    assign busy      = (state_q != LD_IDLE) && (state_q != LD_RUN);
    assign dbg_state = state_q;
    assign xfer      = in_valid && in_ready;
    assign sum_next  = sum_q + in_data;

    always_comb begin
        state_d = state_q;
        wr_fire = 1'b0;
        err_set = 1'b0;
        if (xfer) begin
            case (state_q)
                LD_IDLE:   if (in_data == SYNC_BYTE) state_d = LD_CMD;
                LD_CMD: begin
                    if (in_data == CMD_LOAD_IMEM || in_data == CMD_LOAD_DMEM) begin
                        state_d = LD_ADDR_H;
                    end else if (in_data == CMD_RUN) begin
                        state_d = LD_CSUM;
                    end else begin
                        err_set = 1'b1;
                        state_d = LD_IDLE;
                    end
                end
                LD_ADDR_H: state_d = LD_ADDR_L;
                LD_ADDR_L: state_d = LD_LEN_H;
                LD_LEN_H:  state_d = LD_LEN_L;
                LD_LEN_L:  state_d = ({cnt_q[7:0], in_data} == 16'd0) ? LD_CSUM : LD_DATA_H;
                LD_DATA_H: state_d = LD_DATA_L;
                LD_DATA_L: begin
                    wr_fire = 1'b1;
                    state_d = (cnt_q == 16'd1) ? LD_CSUM : LD_DATA_H;
                end
                LD_CSUM: begin
                    if (sum_next != 8'h00) begin
                        err_set = 1'b1;
                        state_d = LD_IDLE;
                    end else begin
                        state_d = run_q ? LD_RUN : LD_IDLE;
                    end
                end
                LD_RUN:    state_d = LD_RUN;
                default:   state_d = LD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= LD_IDLE;
            sum_q      <= 8'h00;
            tgt_dmem_q <= 1'b0;
            run_q      <= 1'b0;
            addr_q     <= '0;
            cnt_q      <= 16'd0;
            data_h_q   <= 8'h00;
            imem_we    <= 1'b0;
            dmem_we    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 16'h0000;
            err        <= 1'b0;
        end else begin
            state_q <= state_d;
            imem_we <= wr_fire && !tgt_dmem_q;
            dmem_we <= wr_fire && tgt_dmem_q;
            if (err_set) err <= 1'b1;
            if (xfer) begin
                case (state_q)
                    LD_IDLE: if (in_data == SYNC_BYTE) sum_q <= 8'h00;
                    LD_CMD: begin
                        sum_q      <= sum_next;
                        tgt_dmem_q <= (in_data == CMD_LOAD_DMEM);
                        run_q      <= (in_data == CMD_RUN);
                    end
                    // Address bytes shift in; only the low ADDR_W bits survive.
                    LD_ADDR_H: begin
                        sum_q  <= sum_next;
                        addr_q <= ADDR_W'(in_data);
                    end
                    LD_ADDR_L: begin
                        sum_q  <= sum_next;
                        addr_q <= ADDR_W'({addr_q, in_data});
                    end
                    LD_LEN_H: begin
                        sum_q <= sum_next;
                        cnt_q <= {8'h00, in_data};
                    end
                    LD_LEN_L: begin
                        sum_q <= sum_next;
                        cnt_q <= {cnt_q[7:0], in_data};
                    end
                    LD_DATA_H: begin
                        sum_q    <= sum_next;
                        data_h_q <= in_data;
                    end
                    LD_DATA_L: begin
                        sum_q     <= sum_next;
                        mem_addr  <= addr_q;
                        mem_wdata <= {data_h_q, in_data};
                        addr_q    <= addr_q + ADDR_W'(1);
                        cnt_q     <= cnt_q - 16'd1;
                    end
                    LD_CSUM:   sum_q <= sum_next;
                    default:   ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed and randomized frame stimulus for prog_loader, checked against a frame-level model.
module tb_prog_loader;
    import cpu_pkg::*;

    localparam int ADDR_W = 8;

    typedef struct {
        logic        dm;
        logic [7:0]  addr;
        logic [15:0] data;
        int          stamp;
    } wr_t;

    typedef struct {
        logic [7:0] b;
        bit         last_lo;
        bit         busy_after;
    } tx_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic          imem_we;
    logic          dmem_we;
    logic [7:0]    mem_addr;
    logic [15:0]   mem_wdata;
    logic          cpu_rst;
    logic          busy;
    logic          err;
    loader_state_e dbg_state;

    wr_t         exp_q[$];
    wr_t         obs_q[$];
    wr_t         pend_q[$];
    tx_t         tx_q[$];
    logic [15:0] word_q[$];

    int vec_cnt = 0;
    int err_cnt = 0;
    int neg_cyc = 0;
    bit err_exp = 1'b0;
    bit bubbles = 1'b0;

    prog_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(SYNC_DEFAULT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .imem_we   (imem_we),
        .dmem_we   (dmem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst   (cpu_rst),
        .busy      (busy),
        .err       (err),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Write-port monitor: every strobe is recorded with the negedge index it was seen on.
    always @(negedge clk) begin
        wr_t w;
        neg_cyc = neg_cyc + 1;
        if (imem_we || dmem_we) begin
            w.dm    = dmem_we;
            w.addr  = mem_addr;
            w.data  = mem_wdata;
            w.stamp = neg_cyc;
            obs_q.push_back(w);
            vec_cnt++;
            assert (!(imem_we && dmem_we)) else begin
                err_cnt++;
                $error("FAIL both_strobes got imem_we=%0b dmem_we=%0b exp one-hot", imem_we, dmem_we);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        assert (got === exp) else begin
            err_cnt++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b, input bit lo, input bit ba);
        tx_t t;
        t.b          = b;
        t.last_lo    = lo;
        t.busy_after = ba;
        tx_q.push_back(t);
    endtask

    // Builds a load frame from word_q; the checksum makes CMD..CSUM sum to zero when good.
    task automatic build_load(input logic [7:0] cmd, input logic [15:0] addr, input bit good);
        logic [7:0]  sum;
        logic [7:0]  cs;
        logic [15:0] n;
        wr_t         w;
        n   = 16'(word_q.size());
        sum = 8'h00;
        push_byte(SYNC_DEFAULT, 1'b0, 1'b1);
        push_byte(cmd, 1'b0, 1'b1);        sum = sum + cmd;
        push_byte(addr[15:8], 1'b0, 1'b1); sum = sum + addr[15:8];
        push_byte(addr[7:0], 1'b0, 1'b1);  sum = sum + addr[7:0];
        push_byte(n[15:8], 1'b0, 1'b1);    sum = sum + n[15:8];
        push_byte(n[7:0], 1'b0, 1'b1);     sum = sum + n[7:0];
        for (int i = 0; i < int'(n); i++) begin
            push_byte(word_q[i][15:8], 1'b0, 1'b1); sum = sum + word_q[i][15:8];
            push_byte(word_q[i][7:0], 1'b1, 1'b1);  sum = sum + word_q[i][7:0];
            w.dm    = (cmd == CMD_LOAD_DMEM);
            w.addr  = 8'((int'(addr) + i) % (1 << ADDR_W));
            w.data  = word_q[i];
            w.stamp = 0;
            pend_q.push_back(w);
        end
        cs = 8'h00 - sum;
        if (!good) begin
            cs = cs + 8'($urandom_range(1, 255));
            err_exp = 1'b1;
        end
        push_byte(cs, 1'b0, 1'b0);
        word_q.delete();
    endtask

    task automatic send_frame();
        tx_t t;
        wr_t w;
        while (tx_q.size() > 0) begin
            t = tx_q.pop_front();
            if (bubbles) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    in_data  = 8'($urandom);
                    @(posedge clk); #1;
                end
            end
            in_valid = 1'b1;
            in_data  = t.b;
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (t.last_lo && pend_q.size() > 0) begin
                w = pend_q.pop_front();
                w.stamp = neg_cyc + 1;
                exp_q.push_back(w);
            end
            chk("busy_in_frame", busy, t.busy_after);
            chk("in_ready_in_frame", in_ready, 1'b1);
        end
    endtask

    task automatic settle(input bit cpu_rst_exp);
        wr_t o;
        wr_t e;
        repeat (3) @(posedge clk);
        #1;
        chk("write_count", obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            chk("wr_target_dmem", o.dm, e.dm);
            chk("wr_addr", o.addr, e.addr);
            chk("wr_data", o.data, e.data);
            chk("wr_cycle", o.stamp, e.stamp);
        end
        obs_q.delete();
        exp_q.delete();
        pend_q.delete();
        chk("err", err, err_exp);
        chk("cpu_rst", cpu_rst, cpu_rst_exp);
        chk("busy_idle", busy, 1'b0);
        chk("in_ready_idle", in_ready, cpu_rst_exp);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_imem_we"}, imem_we, 1'b0);
        chk({tag, "_dmem_we"}, dmem_we, 1'b0);
        chk({tag, "_mem_addr"}, mem_addr, 8'h00);
        chk({tag, "_mem_wdata"}, mem_wdata, 16'h0000);
        chk({tag, "_cpu_rst"}, cpu_rst, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_err"}, err, 1'b0);
        chk({tag, "_in_ready"}, in_ready, 1'b1);
    endtask

    logic [7:0] jb;
    wr_t        pw;

    initial begin
        // Reset
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        check_reset_values("post_reset");

        // Load imem, literal frame
        push_byte(8'hA5, 0, 1); push_byte(8'h00, 0, 1); push_byte(8'h00, 0, 1);
        push_byte(8'h00, 0, 1); push_byte(8'h00, 0, 1); push_byte(8'h01, 0, 1);
        push_byte(8'h00, 0, 1); push_byte(8'h54, 1, 1); push_byte(8'hAB, 0, 0);
        pw = '{1'b0, 8'h00, 16'h0054, 0}; pend_q.push_back(pw);
        send_frame();
        settle(1'b1);

        // dmem load wrapping past the top of the address space
        push_byte(8'hA5, 0, 1); push_byte(8'h01, 0, 1); push_byte(8'h00, 0, 1);
        push_byte(8'hFF, 0, 1); push_byte(8'h00, 0, 1); push_byte(8'h02, 0, 1);
        push_byte(8'h12, 0, 1); push_byte(8'h34, 1, 1); push_byte(8'hAB, 0, 1);
        push_byte(8'hCD, 1, 1); push_byte(8'h40, 0, 0);
        pw = '{1'b1, 8'hFF, 16'h1234, 0}; pend_q.push_back(pw);
        pw = '{1'b1, 8'h00, 16'hABCD, 0}; pend_q.push_back(pw);
        send_frame();
        settle(1'b1);

        // Zero length with in_valid toggling
        bubbles = 1'b1;
        push_byte(8'hA5, 0, 1); push_byte(8'h00, 0, 1); push_byte(8'h00, 0, 1);
        push_byte(8'h10, 0, 1); push_byte(8'h00, 0, 1); push_byte(8'h00, 0, 1);
        push_byte(8'hF0, 0, 0);
        send_frame();
        settle(1'b1);

        // Randomized load frames with optional leading junk
        for (int f = 0; f < 20; f++) begin
            bubbles = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 2)) begin
                do jb = 8'($urandom); while (jb == SYNC_DEFAULT);
                push_byte(jb, 0, 0);
            end
            repeat ($urandom_range(0, 5)) word_q.push_back(16'($urandom));
            build_load(($urandom_range(0, 1) == 1) ? CMD_LOAD_DMEM : CMD_LOAD_IMEM,
                       16'($urandom), 1'b1);
            send_frame();
            settle(1'b1);
        end
        bubbles = 1'b0;

        // Junk then bad command; a following frame still loads
        push_byte(8'h00, 0, 0); push_byte(8'h13, 0, 0);
        push_byte(8'hA5, 0, 1); push_byte(8'h07, 0, 0);
        err_exp = 1'b1;
        send_frame();
        settle(1'b1);
        repeat (3) word_q.push_back(16'($urandom));
        build_load(CMD_LOAD_IMEM, 16'h3A7C, 1'b1);
        send_frame();
        settle(1'b1);

        // Bad checksum: streamed writes still land
        repeat (2) word_q.push_back(16'($urandom));
        build_load(CMD_LOAD_DMEM, 16'h0080, 1'b0);
        send_frame();
        settle(1'b1);

        // Reset after the DATA_H byte of a frame
        push_byte(8'hA5, 0, 1); push_byte(8'h00, 0, 1); push_byte(8'h00, 0, 1);
        push_byte(8'h10, 0, 1); push_byte(8'h00, 0, 1); push_byte(8'h01, 0, 1);
        push_byte(8'h12, 0, 1);
        send_frame();
        rst = 1'b1;
        #2;
        check_reset_values("mid_frame_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        err_exp = 1'b0;
        repeat (2) word_q.push_back(16'($urandom));
        build_load(CMD_LOAD_IMEM, 16'h00FE, 1'b1);
        send_frame();
        settle(1'b1);

        // RUN with bad checksum keeps the CPU in reset
        push_byte(8'hA5, 0, 1); push_byte(8'hFF, 0, 1); push_byte(8'h02, 0, 0);
        err_exp = 1'b1;
        send_frame();
        settle(1'b1);

        // Good RUN: cpu_rst falls right after the CSUM handshake
        push_byte(8'hA5, 0, 1); push_byte(8'hFF, 0, 1);
        send_frame();
        in_valid = 1'b1;
        in_data  = 8'h01;
        #1;
        chk("cpu_rst_before_csum", cpu_rst, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("cpu_rst_after_run", cpu_rst, 1'b0);
        chk("in_ready_run", in_ready, 1'b0);
        chk("state_run", 32'(dbg_state), 32'(LD_RUN));
        // Bytes offered in RUN are ignored
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            in_data  = (i == 0) ? 8'hA5 : 8'h00;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        settle(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
